// File: rtl/arbiter_pkg.sv
// Shared types and defaults for the 4-phase request arbiter.
// ARBITER_RR_EN selects round-robin instead of fixed priority.
package arbiter_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        REL
    } state_t;

endpackage

// File: rtl/arbiter_pick.sv
// Combinational winner selection over the request vector.
// ARBITER_RR_EN: search starts at i_ptr; otherwise lowest index wins.
module arbiter_pick
    import arbiter_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic [SW-1:0] o_idx,
    output logic          o_valid
);

`ifdef ARBITER_RR_EN
    int            w_sum;
    logic [SW-1:0] w_k;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = 0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = int'(i_ptr) + i;
            if (w_sum >= N) w_sum = w_sum - N;
            w_k = SW'(w_sum);
            if (!o_valid && i_req[w_k]) begin
                o_valid = 1'b1;
                o_idx   = w_k;
            end
        end
    end
`else
    logic [SW-1:0] w_k;
    logic          w_unused;

    assign w_unused = ^i_ptr;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_k = SW'(i);
            if (!o_valid && i_req[w_k]) begin
                o_valid = 1'b1;
                o_idx   = w_k;
            end
        end
    end
`endif

endmodule

// File: rtl/arbiter_nb.sv
// N-channel 4-phase handshake arbiter/merger with registered outputs.
// ARBITER_RR_EN enables the round-robin priority pointer.
module arbiter_nb
    import arbiter_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_in,
    output logic [N-1:0]  ack_in,
    output logic          req_out,
    input  logic          ack_out,
    output logic [SW-1:0] sel,
    output logic          busy
);

    state_t        r_state;
    logic [N-1:0]  r_ack_in;
    logic          r_req_out;
    logic [SW-1:0] r_sel;
    logic          r_busy;
    logic [SW-1:0] w_ptr;
    logic [SW-1:0] w_idx;
    logic          w_valid;

`ifdef ARBITER_RR_EN
    logic [SW-1:0] r_ptr;
    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    arbiter_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .i_req   (req_in),
        .i_ptr   (w_ptr),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ack_in  <= '0;
            r_req_out <= 1'b0;
            r_sel     <= '0;
            r_busy    <= 1'b0;
`ifdef ARBITER_RR_EN
            r_ptr     <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: if (w_valid) begin
                    r_sel     <= w_idx;
                    r_req_out <= 1'b1;
                    r_busy    <= 1'b1;
                    r_state   <= REQ;
                end
                REQ: if (ack_out) begin
                    r_ack_in <= {{(N-1){1'b0}}, 1'b1} << r_sel;
                    r_state  <= ACK;
                end
                ACK: if (!req_in[r_sel]) begin
                    r_req_out <= 1'b0;
                    r_state   <= REL;
                end
                REL: if (!ack_out) begin
                    r_ack_in <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
`ifdef ARBITER_RR_EN
                    r_ptr    <= (r_sel == SW'(N-1)) ? '0 : r_sel + 1'b1;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack_in  = r_ack_in;
    assign req_out = r_req_out;
    assign sel     = r_sel;
    assign busy    = r_busy;

endmodule

// File: tb/tb_arbiter_nb.sv
// Scoreboard bench for arbiter_nb with behavioural requesters/sink.
// Expected grant order follows ARBITER_RR_EN when defined.
module tb_arbiter_nb;
    import arbiter_pkg::*;

    localparam int N  = 4;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req_in = '0;
    logic [N-1:0]  ack_in;
    logic          req_out;
    logic          ack_out = 1'b0;
    logic [SW-1:0] sel;
    logic          busy;

    logic [N-1:0]  want = '0;
    logic [N-1:0]  hold = '0;
    logic [N-1:0]  prev_ack = '0;
    logic          ds_en = 1'b1;
    logic          d1 = 1'b0;
    logic          d2 = 1'b0;
    int            q[$];
    int            n_chk = 0;
    int            n_fail = 0;

    arbiter_nb #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_in  (req_in),
        .ack_in  (ack_in),
        .req_out (req_out),
        .ack_out (ack_out),
        .sel     (sel),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int e;
        @(negedge clk);
        if (rst && ack_in != '0 && prev_ack == '0) begin
            if (q.size() == 0) begin
                chk("spurious_grant", 32'(ack_in), 0);
            end else begin
                e = q.pop_front();
                chk("grant_sel", 32'(sel), e);
                chk("grant_ack", 32'(ack_in), 32'(1) << e);
                if (q.size() == 0) want = '0;
            end
        end
        prev_ack = ack_in;
        for (int i = 0; i < N; i++) begin
            if (ack_in[i]) begin
                req_in[i] = 1'b0;
                if (!hold[i]) want[i] = 1'b0;
            end else begin
                req_in[i] = want[i];
            end
        end
        ack_out = ds_en ? d2 : 1'b0;
        d2 = d1;
        d1 = req_out;
    endtask

    task automatic clear_tb();
        want = '0;
        hold = '0;
        req_in = '0;
        ack_out = 1'b0;
        d1 = 1'b0;
        d2 = 1'b0;
        prev_ack = '0;
        q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_tb();
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (t < 200 && !(q.size() == 0 && !busy &&
               want == '0 && req_in == '0)) begin
            step();
            t++;
        end
        step();
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_q"}, q.size(), 0);
        chk({tag, "_ack"}, 32'(ack_in), 0);
        chk({tag, "_req"}, 32'(req_out), 0);
    endtask

    task automatic wait_ack(input string tag, input logic [N-1:0] pat);
        int t = 0;
        while (t < 100 && ack_in != pat) begin
            step();
            t++;
        end
        chk(tag, 32'(ack_in), 32'(pat));
    endtask

    initial begin
        int chg;
        logic [SW-1:0] s0;

        #1;
        chk("rst_ack", 32'(ack_in), 0);
        chk("rst_req", 32'(req_out), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_busy", 32'(busy), 0);
        do_reset();

        // single requester on channel 1, one-cycle grant latency
        q.push_back(1);
        want = 4'b0010;
        step();
        step();
        chk("lat_req", 32'(req_out), 1);
        chk("lat_sel", 32'(sel), 1);
        chk("lat_busy", 32'(busy), 1);
        drain("single");

        do_reset();
`ifdef ARBITER_RR_EN
        q = '{0, 1, 2, 3, 0};
        hold = 4'b1111;
        want = 4'b1111;
`else
        q = '{1, 1, 1};
        hold = 4'b1010;
        want = 4'b1010;
`endif
        drain("multi");
        hold = '0;

        // late request on channel 2 while channel 0 is in ACK
        do_reset();
        q = '{0, 2};
        want = 4'b0001;
        wait_ack("late_ack0", 4'b0001);
        want[2] = 1'b1;
        repeat (2) step();
        chk("late_ack2_low", 32'(ack_in[2]), 0);
        drain("late");

        // downstream stalls in REQ for 50 cycles
        ds_en = 1'b0;
        q.push_back(2);
        want = 4'b0100;
        repeat (3) step();
        s0 = sel;
        chg = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (sel != s0) chg++;
        end
        chk("stall_req", 32'(req_out), 1);
        chk("stall_sel", 32'(sel), 2);
        chk("stall_ack", 32'(ack_in), 0);
        chk("stall_selchg", chg, 0);
        ds_en = 1'b1;
        drain("stall");

        // asynchronous reset while in ACK for channel 2
        q.push_back(2);
        want = 4'b0100;
        wait_ack("mid_ack", 4'b0100);
        rst = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack_in), 0);
        chk("mid_rst_req", 32'(req_out), 0);
        chk("mid_rst_sel", 32'(sel), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        clear_tb();
        repeat (2) step();
        rst = 1'b1;

        // first edge after reset release arbitrates
        q.push_back(3);
        want = 4'b1000;
        step();
        step();
        chk("post_req", 32'(req_out), 1);
        chk("post_sel", 32'(sel), 3);
        drain("post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter_nb.md
ARBITER_NB -- requirements
Module: arbiter_nb

Interface
REQ-001 Parameter N SHALL be the number of requesting channels; default 4; legal range 2..16.
REQ-002 Parameter SW SHALL be the select width; default $clog2(N); not overridden by users.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Port req_in  input  N  SHALL carry the upstream 4-phase requests, one bit per channel.
REQ-006 Port ack_in  output  N  SHALL carry the upstream 4-phase acknowledges, one-hot or zero.
REQ-007 Port req_out  output  1  SHALL carry the merged downstream 4-phase request.
REQ-008 Port ack_out  input  1  SHALL carry the downstream 4-phase acknowledge.
REQ-009 Port sel  output  SW  SHALL give the index of the granted channel, held stable for the whole handshake.
REQ-010 Port busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-011 FSM states SHALL be IDLE, REQ, ACK, REL; all outputs registered.
REQ-012 IDLE: if any req_in bit is high, the winner SHALL be latched into sel and the FSM SHALL go to REQ with req_out=1 on the next cycle.
REQ-013 REQ: on ack_out=1 the FSM SHALL go to ACK and raise ack_in[sel] on the next cycle; other ack_in bits stay 0.
REQ-014 ACK: on req_in[sel]=0 the FSM SHALL go to REL and drop req_out on the next cycle.
REQ-015 REL: on ack_out=0 the FSM SHALL drop ack_in[sel], update the priority pointer, and return to IDLE on the next cycle.
REQ-016 Each handshake edge SHALL have exactly one cycle of latency from input change to output change.
REQ-017 Requests arriving on non-granted channels during a handshake SHALL be ignored until IDLE; no request is lost, it is re-evaluated in IDLE.
REQ-018 Simultaneous requests in IDLE SHALL be resolved in one cycle per the configured policy (REQ-024/025).
REQ-019 A granted requester dropping req_in[sel] while in REQ SHALL be ignored; the FSM still waits for ack_out=1 (4-phase rule is the requester's obligation).
REQ-020 sel SHALL not change outside IDLE; sel outside 0..N-1 SHALL never be produced.

Reset
REQ-021 On rst=0, regardless of state: FSM=IDLE, ack_in=0, req_out=0, sel=0, busy=0, priority pointer=0.
REQ-022 Reset asserted mid-handshake SHALL abort it immediately; upstream and downstream restart from all-low.
REQ-023 After rst deassertion the first arbitration SHALL occur on the first clk edge with any req_in high.

Configuration
REQ-024 With ARBITER_RR_EN defined, arbitration SHALL be round-robin: search starts at pointer, pointer becomes sel+1 (mod N) on REL->IDLE.
REQ-025 Without ARBITER_RR_EN, arbitration SHALL be fixed priority, lowest index wins; pointer logic absent.

Structure
REQ-026 Package arbiter_pkg SHALL hold the FSM state enum and the default N constant.
REQ-027 Winner selection SHALL be a combinational sub-module arbiter_pick (inputs: request vector, pointer; output: index, valid).
REQ-028 arbiter_nb SHALL contain only the FSM, sel/pointer registers and output registers.

Verification
REQ-029 N=4, req_in=0010, ack_out follows req_out after 2 cycles -> sel=1, ack_in=0010 then 0000, full cycle returns to IDLE, busy low.
REQ-030 RR build, req_in=1111 held, each handshake completed -> grant order sel=0,1,2,3,0.
REQ-031 Fixed build, req_in=1010 held across 3 handshakes -> sel=1 each time, channel 3 starved.
REQ-032 During ACK for sel=0, req_in[2] rises -> ack_in[2] stays 0 until next IDLE, then channel 2 granted.
REQ-033 rst=0 asserted in ACK state -> same cycle ack_in=0, req_out=0, sel=0, busy=0.
REQ-034 ack_out held 0 for 50 cycles in REQ -> req_out stays 1, sel stable, no ack_in asserted.
